// File: rtl/t0_readout_arbiter_pkg.sv
// Shared defaults and output-slot state encoding for the T0 readout arbiter.
package t0_readout_arbiter_pkg;

    localparam int T0_CHANNEL    = 8;
    localparam int T0_DATA_WIDTH = 32;
    localparam int T0_CNT_WIDTH  = 16;

    typedef logic [0:0] slot_state_t;

    localparam logic [0:0] SLOT_EMPTY = 1'b0;
    localparam logic [0:0] SLOT_FULL  = 1'b1;

endpackage

// File: rtl/t0_readout_arbiter_rr_arbiter.sv
// Combinational round-robin picker over channels 1..CHANNEL-1; channel 0 never wins.
module rr_arbiter #(
    parameter int CHANNEL  = 8,
    parameter int ID_WIDTH = $clog2(CHANNEL)
) (
    input  logic [CHANNEL-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [CHANNEL-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_idx,
    output logic                grant_any
);

    localparam logic [ID_WIDTH-1:0] FIRST_CH = ID_WIDTH'(1);
    localparam logic [ID_WIDTH-1:0] LAST_CH  = ID_WIDTH'(CHANNEL - 1);
    localparam logic [CHANNEL-1:0]  CH0_MASK = CHANNEL'(1);

    logic [CHANNEL-1:0]  req_m;
    logic [ID_WIDTH-1:0] idx;

    assign req_m = req & ~CH0_MASK;

    // Walk from the pointer, wrapping LAST_CH -> FIRST_CH; first requester found wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = ptr;
        for (int k = 0; k < CHANNEL - 1; k++) begin
            if (!grant_any && req_m[idx]) begin
                grant_any  = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
            idx = (idx == LAST_CH) ? FIRST_CH : idx + FIRST_CH;
        end
    end

endmodule

// File: rtl/t0_readout_arbiter.sv
// Serializes per-channel T0 results onto one valid/ready stream with one-deep
// hold per channel, round-robin grant and sticky overflow tracking.
//
//   state      | meaning
//   SLOT_EMPTY | no word presented, m_valid = 0
//   SLOT_FULL  | word presented on m_chan/m_data, held until m_ready
module t0_readout_arbiter
    import t0_readout_arbiter_pkg::*;
#(
    parameter int CHANNEL    = T0_CHANNEL,
    parameter int DATA_WIDTH = T0_DATA_WIDTH,
    parameter int ID_WIDTH   = $clog2(CHANNEL),
    parameter int CNT_WIDTH  = T0_CNT_WIDTH
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [CHANNEL-1:0]            t0_valid,
    input  logic [CHANNEL*DATA_WIDTH-1:0] t0_data,
    input  logic                          ovf_clr,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [ID_WIDTH-1:0]           m_chan,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic [CHANNEL-1:0]            ovf_flag,
    output logic [CNT_WIDTH-1:0]          drop_cnt
);

    localparam logic [ID_WIDTH-1:0] FIRST_CH = ID_WIDTH'(1);
    localparam logic [ID_WIDTH-1:0] LAST_CH  = ID_WIDTH'(CHANNEL - 1);
    localparam logic [CHANNEL-1:0]  CH0_MASK = CHANNEL'(1);

    slot_state_t           state;
    logic [CHANNEL-1:0]    pend;
    logic [DATA_WIDTH-1:0] hold [CHANNEL];
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [CHANNEL-1:0]    gnt;
    logic [ID_WIDTH-1:0]   gnt_idx;
    logic                  gnt_any;
    logic                  load;
    logic [CHANNEL-1:0]    granted;
    logic [CHANNEL-1:0]    cap;
    logic [CHANNEL-1:0]    drop;
    logic [CNT_WIDTH-1:0]  drop_base;
    logic [CNT_WIDTH:0]    drop_sum;
    logic                  unused_ch0;

    assign unused_ch0 = ^{t0_valid[0], t0_data[DATA_WIDTH-1:0]};

    rr_arbiter #(
        .CHANNEL  (CHANNEL),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_arbiter (
        .req       (pend),
        .ptr       (rr_ptr),
        .grant     (gnt),
        .grant_idx (gnt_idx),
        .grant_any (gnt_any)
    );

    assign m_valid = (state == SLOT_FULL);
    assign load    = (state == SLOT_EMPTY) || m_ready;
    assign granted = (load && gnt_any) ? gnt : '0;

    // A channel granted this cycle frees its hold, so a same-cycle sample is kept, not dropped.
    assign cap  = t0_valid & (~pend | granted) & ~CH0_MASK;
    assign drop = t0_valid & pend & ~granted & ~CH0_MASK;

    always_comb begin
        drop_base = ovf_clr ? '0 : drop_cnt;
        drop_sum  = {1'b0, drop_base};
        for (int i = 1; i < CHANNEL; i++) begin
            drop_sum = drop_sum + {{CNT_WIDTH{1'b0}}, drop[i]};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend <= '0;
            for (int i = 0; i < CHANNEL; i++) begin
                hold[i] <= '0;
            end
        end else begin
            pend <= (pend & ~granted) | cap;
            for (int i = 1; i < CHANNEL; i++) begin
                if (cap[i]) begin
                    hold[i] <= t0_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= SLOT_EMPTY;
            m_chan <= '0;
            m_data <= '0;
            rr_ptr <= FIRST_CH;
        end else if (load) begin
            if (gnt_any) begin
                state  <= SLOT_FULL;
                m_chan <= gnt_idx;
                m_data <= hold[gnt_idx];
                rr_ptr <= (gnt_idx == LAST_CH) ? FIRST_CH : gnt_idx + FIRST_CH;
            end else begin
                state <= SLOT_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovf_flag <= '0;
            drop_cnt <= '0;
        end else begin
            ovf_flag <= (ovf_clr ? '0 : ovf_flag) | drop;
            drop_cnt <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_t0_readout_arbiter.sv
// Scoreboard bench for t0_readout_arbiter: reference model predicts grants, monitor checks.
module tb_t0_readout_arbiter;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int IW = 3;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [N-1:0]    t0_valid = '0;
    logic [N*DW-1:0] t0_data = '0;
    logic            ovf_clr = 1'b0;
    logic            m_ready = 1'b0;
    logic            m_valid;
    logic [IW-1:0]   m_chan;
    logic [DW-1:0]   m_data;
    logic [N-1:0]    ovf_flag;
    logic [CW-1:0]   drop_cnt;

    t0_readout_arbiter #(
        .CHANNEL    (N),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .t0_valid (t0_valid),
        .t0_data  (t0_data),
        .ovf_clr  (ovf_clr),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_chan   (m_chan),
        .m_data   (m_data),
        .ovf_flag (ovf_flag),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: per-channel single-slot mailboxes, one output slot, rotating priority.
    bit            md_pend [N];
    logic [DW-1:0] md_hold [N] = '{default: '0};
    bit            md_full = 1'b0;
    int            md_ptr = 1;
    logic [N-1:0]  md_ovf = '0;
    int            md_drop = 0;
    logic [IW+DW-1:0] exp_q [$];
    int            obs_chan [$];

    always @(posedge clk or negedge resetn) begin
        int g;
        int c;
        int drops;
        if (!resetn) begin
            for (int i = 0; i < N; i++) begin
                md_pend[i] = 1'b0;
                md_hold[i] = '0;
            end
            md_full = 1'b0;
            md_ptr  = 1;
            md_ovf  = '0;
            md_drop = 0;
            exp_q.delete();
        end else begin
            g = 0;
            if (!md_full || m_ready) begin
                for (int k = 0; k < N - 1; k++) begin
                    c = (md_ptr - 1 + k) % (N - 1) + 1;
                    if (g == 0 && md_pend[c]) g = c;
                end
                if (g != 0) begin
                    exp_q.push_back({g[IW-1:0], md_hold[g]});
                    md_pend[g] = 1'b0;
                    md_ptr = g % (N - 1) + 1;
                    md_full = 1'b1;
                end else begin
                    md_full = 1'b0;
                end
            end
            if (ovf_clr) begin
                md_ovf  = '0;
                md_drop = 0;
            end
            drops = 0;
            for (int i = 1; i < N; i++) begin
                if (t0_valid[i]) begin
                    if (!md_pend[i]) begin
                        md_pend[i] = 1'b1;
                        md_hold[i] = t0_data[i*DW +: DW];
                    end else begin
                        md_ovf[i] = 1'b1;
                        drops++;
                    end
                end
            end
            md_drop = (md_drop + drops > 65535) ? 65535 : md_drop + drops;
        end
    end

    always @(negedge clk) begin
        logic [IW+DW-1:0] f;
        check("m_valid", m_valid, md_full);
        check("ovf_flag", ovf_flag, md_ovf);
        check("drop_cnt", drop_cnt, md_drop);
        if (m_valid) begin
            check("sb_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                f = exp_q[0];
                check("m_chan", m_chan, f[IW+DW-1:DW]);
                check("m_data", m_data, f[DW-1:0]);
                if (m_ready) begin
                    obs_chan.push_back(int'(m_chan));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic [N-1:0] v, input logic rdy, input logic clr);
        t0_valid = v;
        m_ready  = rdy;
        ovf_clr  = clr;
        for (int i = 0; i < N; i++) t0_data[i*DW +: DW] = $urandom;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order [9] = '{1, 2, 3, 4, 5, 6, 7, 3, 5};
        logic [N-1:0] v;

        repeat (2) @(posedge clk);
        #2;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_ovf", ovf_flag, 0);
        resetn = 1'b1;

        // fairness from the reset pointer
        obs_chan.delete();
        drive(8'hFE, 1'b1, 1'b0);
        repeat (8) drive('0, 1'b1, 1'b0);
        drive(8'h28, 1'b1, 1'b0);
        repeat (4) drive('0, 1'b1, 1'b0);
        check("fair_count", obs_chan.size(), 9);
        for (int k = 0; k < 9 && k < obs_chan.size(); k++) check("fair_order", obs_chan[k], exp_order[k]);

        // single word, two-cycle latency
        t0_valid = 8'h04;
        m_ready  = 1'b1;
        for (int i = 0; i < N; i++) t0_data[i*DW +: DW] = $urandom;
        t0_data[2*DW +: DW] = 32'h0000_1234;
        @(posedge clk);
        #2;
        t0_valid = '0;
        check("single_early", m_valid, 0);
        @(posedge clk);
        #2;
        check("single_valid", m_valid, 1);
        check("single_chan", m_chan, 2);
        check("single_data", m_data, 32'h1234);
        check("single_ovf", ovf_flag, 0);
        @(posedge clk);
        #2;
        check("single_gone", m_valid, 0);

        // backpressure and overflow
        drive(8'h02, 1'b0, 1'b0);
        repeat (12) drive('0, 1'b0, 1'b0);
        drive(8'h02, 1'b0, 1'b0);
        drive('0, 1'b0, 1'b0);
        drive(8'h02, 1'b0, 1'b0);
        check("bp_ovf", ovf_flag, 8'h02);
        check("bp_drop", drop_cnt, 1);

        // clear coinciding with a new drop
        drive(8'h10, 1'b0, 1'b0);
        drive(8'h10, 1'b0, 1'b1);
        check("clr_drop_ovf", ovf_flag, 8'h10);
        check("clr_drop_cnt", drop_cnt, 1);
        repeat (6) drive('0, 1'b1, 1'b0);

        // channel 0 is ignored
        drive('0, 1'b1, 1'b1);
        repeat (5) drive(8'h01, 1'b1, 1'b0);
        check("ch0_valid", m_valid, 0);
        check("ch0_drop", drop_cnt, 0);
        check("ch0_ovf", ovf_flag, 0);

        // randomized traffic
        repeat (3000) begin
            v = N'($urandom & $urandom);
            drive(v, $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
        end
        repeat (8) drive('0, 1'b1, 1'b0);

        // asynchronous reset mid-transfer
        drive(8'h1E, 1'b0, 1'b0);
        drive('0, 1'b0, 1'b0);
        check("pre_rst_valid", m_valid, 1);
        #1;
        resetn = 1'b0;
        #1;
        check("arst_valid", m_valid, 0);
        check("arst_chan", m_chan, 0);
        check("arst_data", m_data, 0);
        check("arst_ovf", ovf_flag, 0);
        check("arst_drop", drop_cnt, 0);
        @(posedge clk);
        #2;
        resetn = 1'b1;
        drive(8'h80, 1'b1, 1'b0);
        drive('0, 1'b1, 1'b0);
        check("post_rst_valid", m_valid, 1);
        check("post_rst_chan", m_chan, 7);
        repeat (3) drive('0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
